// File: rtl/sha256_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_pkg : SHA-256 constants, word functions and shared types    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sha256_pkg;

    typedef logic [31:0]      word_t;
    typedef logic [7:0][31:0] state_t;   // word k at bits [32k+31:32k]

    localparam int ROUNDS = 64;

    // Working-variable positions inside state_t
    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_C = 2;
    localparam int IDX_D = 3;
    localparam int IDX_E = 4;
    localparam int IDX_F = 5;
    localparam int IDX_G = 6;
    localparam int IDX_H = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_round : one combinational SHA-256 compression round         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sha256_round
    import sha256_pkg::*;
(
    input  state_t i_state,
    input  word_t  i_k,
    input  word_t  i_w,
    output state_t o_state
);

    word_t w_t1;
    word_t w_t2;

    assign w_t1 = i_state[IDX_H] + bsig1(i_state[IDX_E])
                + ch(i_state[IDX_E], i_state[IDX_F], i_state[IDX_G]) + i_k + i_w;
    assign w_t2 = bsig0(i_state[IDX_A]) + maj(i_state[IDX_A], i_state[IDX_B], i_state[IDX_C]);

    // Concatenation runs from h (word 7) down to a (word 0)
    assign o_state = {i_state[IDX_G], i_state[IDX_F], i_state[IDX_E], i_state[IDX_D] + w_t1,
                      i_state[IDX_C], i_state[IDX_B], i_state[IDX_A], w_t1 + w_t2};

endmodule
`default_nettype wire

// File: rtl/sha256_fold_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_fold_core : folded SHA-256 compression, UNROLL rounds/clock |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sha256_fold_core
    import sha256_pkg::*;
#(
    parameter int UNROLL      = 1,
    parameter int ADD_FEEDFWD = 1,
    parameter int TAG_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [255:0]     in_state,
    input  logic [511:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     out_hash,
    output logic [TAG_W-1:0] out_tag
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256_fold_core: UNROLL must be 1, 2, 4 or 8");
    end

    fsm_t              r_fsm;
    logic [6:0]        r_cnt;
    state_t            r_vars;
    state_t            r_ff;
    state_t            r_hash;
    logic [15:0][31:0] r_win;
    logic [TAG_W-1:0]  r_tag;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_out_valid;

    state_t            w_chain [0:UNROLL];
    word_t             w_ext   [0:15+UNROLL];
    logic [15:0][31:0] w_win_nxt;
    state_t            w_final;

    assign in_ready  = (r_fsm == ST_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign out_hash  = r_hash;
    assign out_tag   = r_out_tag;

    assign w_chain[0] = r_vars;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [5:0] w_kidx;
        assign w_kidx = r_cnt[5:0] + 6'(u);
        sha256_round u_round (
            .i_state (w_chain[u]),
            .i_k     (K[w_kidx]),
            .i_w     (r_win[u]),
            .o_state (w_chain[u+1])
        );
    end

    // Window holds W[t..t+15]; extend by UNROLL words, then slide by UNROLL
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_ext[j] = r_win[j];
        end
        for (int j = 16; j < 16 + UNROLL; j++) begin
            w_ext[j] = ssig1(w_ext[j-2]) + w_ext[j-7] + ssig0(w_ext[j-15]) + w_ext[j-16];
        end
    end

    for (genvar j = 0; j < 16; j++) begin : g_win_nxt
        assign w_win_nxt[j] = w_ext[j+UNROLL];
    end

    if (ADD_FEEDFWD != 0) begin : g_feedfwd
        for (genvar k = 0; k < 8; k++) begin : g_word
            assign w_final[k] = r_vars[k] + r_ff[k];
        end
    end else begin : g_raw
        assign w_final = r_vars;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_hash      <= '0;
            r_out_tag   <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_vars <= in_state;
                        r_ff   <= in_state;
                        r_win  <= in_data;
                        r_tag  <= in_tag;
                        r_cnt  <= '0;
                        r_fsm  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Counter at ROUNDS means all rounds are in r_vars; publish on this edge
                    if (r_cnt == 7'(ROUNDS)) begin
                        r_hash      <= w_final;
                        r_out_tag   <= r_tag;
                        r_out_valid <= 1'b1;
                        r_fsm       <= ST_DONE;
                    end else begin
                        r_vars <= w_chain[UNROLL];
                        r_win  <= w_win_nxt;
                        r_cnt  <= r_cnt + 7'(UNROLL);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
